alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit add/subtract/compare datapath between two requesters. It grants one request at a time and latches that request's operands. It then waits a fixed number of cycles for the ripple-carry adder to settle, captures the result, and returns it with a valid/ready response handshake. It sits between the ALU's requesting units and the shared adder built from the team's 32-bit add / fulladder modules.

---
 rtl/alu_share_arbiter_pkg.sv | 23 ++
 rtl/alu_share_arbiter_if.sv | 31 +++
 rtl/alu_share_core.sv | 46 ++++
 rtl/alu_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants and types for the two-requester shared add/sub/compare unit.
package alu_share_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Two's-complement overflow from the sign bits of both adder inputs and the sum.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester and response bundle between the ALU requesting units and the shared adder.
interface alu_share_arbiter_if;
    import alu_share_arbiter_pkg::*;

    logic              req0;
    logic [1:0]        op0;
    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] y0;
    logic              req1;
    logic [1:0]        op1;
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] y1;
    logic              gnt0;
    logic              gnt1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] result;
    logic              overflow;

    modport master (
        output req0, op0, x0, y0, req1, op1, x1, y1, rsp_ready,
        input  gnt0, gnt1, rsp_valid, rsp_id, result, overflow
    );

    modport slave (
        input  req0, op0, x0, y0, req1, op1, x1, y1, rsp_ready,
        output gnt0, gnt1, rsp_valid, rsp_id, result, overflow
    );

endinterface

// File: rtl/alu_share_core.sv
// Combinational 32-bit ripple-carry add/subtract datapath with overflow and compare flags.
module alu_share_core
    import alu_share_arbiter_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] sum,
    output logic              carry_out,
    output logic              ovf,
    output logic              set_lt
);

    logic [DATA_W-1:0] b_s;
    logic              cin_s;
    logic              carry_s;

    // Second adder operand and carry-in: subtraction and compares use x + ~y + 1.
    always_comb begin
        b_s   = y;
        cin_s = 1'b0;
        if (op == OP_ADD) begin
            b_s   = y;
            cin_s = 1'b0;
        end else begin
            b_s   = ~y;
            cin_s = 1'b1;
        end
    end

    // Ripple-carry chain of full-adder cells, bit 0 first.
    always_comb begin
        carry_s = cin_s;
        sum     = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            sum[i]  = x[i] ^ b_s[i] ^ carry_s;
            carry_s = (x[i] & b_s[i]) | (carry_s & (x[i] ^ b_s[i]));
        end
        carry_out = carry_s;
    end

    assign ovf    = signed_ovf(x[DATA_W-1], b_s[DATA_W-1], sum[DATA_W-1]);
    // Signed less-than: the sign of x - y is wrong exactly when the subtraction overflowed.
    assign set_lt = sum[DATA_W-1] ^ ovf;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one ripple add/sub/compare datapath between two requesters.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned WIDTH      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_e           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             last_gnt_r;
    logic             own_r;
    logic             gnt0_r;
    logic             gnt1_r;
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic             overflow_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] result_r;

    logic             any_req_s;
    logic             pick0_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] res_s;
    logic             cout_s;
    logic             ovf_s;
    logic             set_lt_s;
    logic             ovf_sel_s;

    alu_share_core u_core (
        .op        (op_r),
        .x         (x_r),
        .y         (y_r),
        .sum       (sum_s),
        .carry_out (cout_s),
        .ovf       (ovf_s),
        .set_lt    (set_lt_s)
    );

    // Round-robin pick: a lone request wins, on contention the requester not granted last wins.
    always_comb begin
        any_req_s = bus.req0 | bus.req1;
        pick0_s   = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick0_s = last_gnt_r;
        end else if (bus.req0) begin
            pick0_s = 1'b1;
        end else begin
            pick0_s = 1'b0;
        end
    end

    // Result selection from the settled adder outputs.
    always_comb begin
        res_s     = sum_s;
        ovf_sel_s = ovf_s;
        case (op_r)
            OP_ADD, OP_SUB: begin
                res_s     = sum_s;
                ovf_sel_s = ovf_s;
            end
            OP_SLT: begin
                res_s     = {{(WIDTH-1){1'b0}}, set_lt_s};
                ovf_sel_s = 1'b0;
            end
            OP_SLTU: begin
                res_s     = {{(WIDTH-1){1'b0}}, ~cout_s};
                ovf_sel_s = 1'b0;
            end
            default: begin
                res_s     = {WIDTH{1'b0}};
                ovf_sel_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with operand, result and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            last_gnt_r  <= 1'b1;
            own_r       <= 1'b0;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            overflow_r  <= 1'b0;
            op_r        <= 2'b00;
            x_r         <= {WIDTH{1'b0}};
            y_r         <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
        end else begin
            gnt0_r <= 1'b0;
            gnt1_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        gnt0_r     <= pick0_s;
                        gnt1_r     <= ~pick0_s;
                        last_gnt_r <= ~pick0_s;
                        own_r      <= ~pick0_s;
                        op_r       <= pick0_s ? bus.op0 : bus.op1;
                        x_r        <= pick0_s ? bus.x0  : bus.x1;
                        y_r        <= pick0_s ? bus.y0  : bus.y1;
                        cnt_r      <= CNT_LOAD;
                        state_r    <= ST_SETTLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        result_r   <= res_s;
                        overflow_r <= ovf_sel_s;
                        rsp_id_r   <= own_r;
                        state_r    <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Response is presented one cycle after the result registers load.
                    if (!rsp_valid_r) begin
                        rsp_valid_r <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_r;
    assign bus.gnt1      = gnt1_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.result    = result_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed operations, round-robin, backpressure, reset.
module tb_alu_share_arbiter;

    localparam int S = 4;
    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] SLT  = 2'b10;
    localparam logic [1:0] SLTU = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    bit          exp_gnt[$];
    logic [33:0] exp_rsp[$];
    int          gnt_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter_if bus();

    alu_share_arbiter #(.SETTLE_CYC(S), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input bit id, input bit req, input logic [1:0] op,
                         input logic [31:0] x, input logic [31:0] y);
        if (id) begin
            bus.req1 = req; bus.op1 = op; bus.x1 = x; bus.y1 = y;
        end else begin
            bus.req0 = req; bus.op0 = op; bus.x0 = x; bus.y0 = y;
        end
    endtask

    task automatic expect_op(input bit id, input logic [31:0] er, input bit eo);
        exp_gnt.push_back(id);
        exp_rsp.push_back({id, eo, er});
    endtask

    task automatic wait_gnt(input bit id);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = id ? bus.gnt1 : bus.gnt0;
        end
        check("gnt_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_rsp.size() != 0; i++) @(negedge clk);
        check("rsp_drain_left", exp_rsp.size(), 32'd0);
        exp_rsp.delete();
    endtask

    task automatic issue(input bit id, input logic [1:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input bit eo);
        expect_op(id, er, eo);
        drive(id, 1'b1, op, x, y);
        wait_gnt(id);
        drive(id, 1'b0, op, x, y);
        drain();
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk);
        #1 bus.rsp_ready = v;
    endtask

    // Monitor: grant order, latency and response contents against the scoreboard.
    initial begin
        logic [33:0] e;
        logic        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.gnt0 || bus.gnt1) begin
                    check("grant_onehot", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
                    if (exp_gnt.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_grant: actual gnt0=%0b gnt1=%0b required=none", bus.gnt0, bus.gnt1);
                    end else begin
                        check("grant_id", {31'd0, bus.gnt1}, {31'd0, exp_gnt.pop_front()});
                    end
                    gnt_cyc.push_back(cyc);
                end
                if (bus.rsp_valid && !prev_valid) begin
                    if (gnt_cyc.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rsp: actual rsp_valid=1 required=no grant outstanding");
                    end else begin
                        check("latency", cyc - gnt_cyc.pop_front(), S + 1);
                    end
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL extra_rsp: actual result=0x%08h required=none", bus.result);
                    end else begin
                        e = exp_rsp.pop_front();
                        check("rsp_id",   {31'd0, bus.rsp_id},   {31'd0, e[33]});
                        check("overflow", {31'd0, bus.overflow}, {31'd0, e[32]});
                        check("result",   bus.result,            e[31:0]);
                    end
                end
                prev_valid = bus.rsp_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  prev;
        bit  got;
        bit  seen;
        drive(1'b0, 1'b0, ADD, 32'd0, 32'd0);
        drive(1'b1, 1'b0, ADD, 32'd0, 32'd0);
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_gnt0",      {31'd0, bus.gnt0},      32'd0);
        check("rst_gnt1",      {31'd0, bus.gnt1},      32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
        check("rst_result",    bus.result,             32'd0);
        check("rst_overflow",  {31'd0, bus.overflow},  32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, ADD,  32'd7,         32'd5,      32'd12,        1'b0);
        issue(1'b1, SUB,  32'h8000_0000, 32'd1,      32'h7FFF_FFFF, 1'b1);
        issue(1'b0, SLT,  32'hFFFF_FFFF, 32'd1,      32'd1,         1'b0);
        issue(1'b1, SLTU, 32'hFFFF_FFFF, 32'd1,      32'd0,         1'b0);
        issue(1'b0, SLT,  32'h0000_1234, 32'h1234,   32'd0,         1'b0);
        issue(1'b1, SLTU, 32'h0000_1234, 32'h1234,   32'd0,         1'b0);
        issue(1'b0, ADD,  32'h7FFF_FFFF, 32'd1,      32'h8000_0000, 1'b1);
        issue(1'b1, SLT,  32'h8000_0000, 32'd1,      32'd1,         1'b0);

        // Contention from reset: grants alternate starting with requester 0.
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) expect_op(1'b0, 32'd30, 1'b0);
            else            expect_op(1'b1, 32'hFFFF_FFFE, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, ADD, 32'd10, 32'd20);
        drive(1'b1, 1'b1, SUB, 32'd5,  32'd7);
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                got = bus.gnt0 | bus.gnt1;
            end
            check("rr_gnt_seen", {31'd0, got}, 32'd1);
            if (g > 0) check("rr_spacing", cyc - prev, S + 3);
            prev = cyc;
        end
        drive(1'b0, 1'b0, ADD, 32'd0, 32'd0);
        drive(1'b1, 1'b0, SUB, 32'd0, 32'd0);
        drain();

        // Backpressure with requester 1 waiting behind a stalled response.
        set_ready(1'b0);
        expect_op(1'b0, 32'd123, 1'b0);
        drive(1'b0, 1'b1, ADD, 32'd100, 32'd23);
        wait_gnt(1'b0);
        drive(1'b0, 1'b0, ADD, 32'd100, 32'd23);
        expect_op(1'b1, 32'd2, 1'b0);
        drive(1'b1, 1'b1, ADD, 32'd1, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.rsp_valid;
        end
        check("bp_valid_seen", {31'd0, got}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid_held", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_result_held", bus.result, 32'd123);
            check("bp_id_held", {31'd0, bus.rsp_id}, 32'd0);
            check("bp_no_gnt1", {31'd0, bus.gnt1}, 32'd0);
        end
        set_ready(1'b1);
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_dropped", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_no_gnt1_idle", {31'd0, bus.gnt1}, 32'd0);
        @(negedge clk);
        check("bp_gnt1_after", {31'd0, bus.gnt1}, 32'd1);
        drive(1'b1, 1'b0, ADD, 32'd1, 32'd1);
        drain();

        // Reset while settling: operation dropped, outputs cleared asynchronously.
        exp_gnt.push_back(1'b0);
        drive(1'b0, 1'b1, ADD, 32'd9, 32'd9);
        wait_gnt(1'b0);
        drive(1'b0, 1'b0, ADD, 32'd9, 32'd9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt0",      {31'd0, bus.gnt0},      32'd0);
        check("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("mid_rst_result",    bus.result,             32'd0);
        check("mid_rst_overflow",  {31'd0, bus.overflow},  32'd0);
        check("mid_rst_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
        exp_gnt.delete();
        exp_rsp.delete();
        gnt_cyc.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_reset", {31'd0, seen}, 32'd0);
        issue(1'b0, ADD, 32'd2, 32'd3, 32'd5, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
